prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 16, instruction-memory address width.
REQ-002 Parameter INSTR_W, default 28, instruction word width (4-bit opcode + 24-bit operand field).
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 iStart  input  1  one-cycle pulse; begins a load session when idle.
REQ-006 iWordCount  input  ADDR_W  number of instructions to load; sampled on accepted iStart.
REQ-007 iByte  input  8  serial program byte.
REQ-008 iByteValid  input  1  iByte valid this cycle.
REQ-009 oByteReady  output  1  loader accepts iByte this cycle; a byte transfers when iByteValid && oByteReady.
REQ-010 oWrEn  output  1  one-cycle instruction-memory write strobe.
REQ-011 oWrAddress  output  ADDR_W  write address.
REQ-012 oWrData  output  INSTR_W  assembled instruction word.
REQ-013 oBusy  output  1  session in progress.
REQ-014 oCpuHold  output  1  holds the CPU fetch path stalled; equals oBusy.
REQ-015 oDone  output  1  one-cycle pulse on successful completion.
REQ-016 oError  output  1  sticky error flag; cleared by the next accepted iStart or by reset.

Function
REQ-017 FSM states: IDLE, RECV, WRITE, CHECK (only when REQ-030 is enabled), DONE, ERR.
REQ-018 IDLE: iStart with iWordCount>0 -> RECV, address counter=0, byte index=0, oError cleared; iStart with iWordCount=0 -> DONE, no writes.
REQ-019 iStart is ignored in every state except IDLE and ERR.
REQ-020 RECV: oByteReady=1; each transfer stores one byte, big-endian: byte0 -> bits[27:24] (its upper nibble SHALL be 0), byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
REQ-021 byte0 with a nonzero upper nibble -> ERR, no write, oError=1.
REQ-022 Transfer of byte3 in cycle N -> WRITE; oWrEn=1 in cycle N+1 with oWrAddress=current counter and oWrData=assembled word; oByteReady=0 in WRITE.
REQ-023 WRITE: counter increments; if counter+1 == word count -> DONE (or CHECK if enabled), else -> RECV with byte index=0.
REQ-024 Addresses SHALL run 0..iWordCount-1 with no wrap-around; iWordCount up to 2^ADDR_W-1.
REQ-025 DONE: oDone=1 for exactly one cycle, then -> IDLE.
REQ-026 ERR: oBusy=0, oError=1; iStart is accepted exactly as in IDLE.
REQ-027 oBusy=1 in RECV, WRITE and CHECK only; oWrEn=0 outside WRITE.

Reset
REQ-028 Reset low at any rising edge -> IDLE; partial word discarded; oWrEn, oByteReady, oBusy, oCpuHold, oDone, oError=0; oWrAddress, oWrData=0.
REQ-029 A reset during a session SHALL generate no further write strobes.

Configuration
REQ-030 LOADER_CHECKSUM_EN defined: a running XOR of all data bytes is kept; after the last write the FSM enters CHECK (oByteReady=1), accepts one checksum byte, and goes to DONE on match or ERR (oError=1) on mismatch; iWordCount=0 also requires a checksum byte equal to 8'h00. Not defined: no CHECK state, no checksum logic, DONE directly after the last write.

Structure
REQ-031 State encodings, byte-per-word constant (4), and opcode/operand field widths SHALL live in the shared definitions header alongside the opcode definitions.
REQ-032 One sub-module prog_word_packer (byte index, shift/assemble, nibble check) SHALL be instantiated; the FSM and address counter stay in prog_loader.

Verification
REQ-033 iWordCount=2, bytes 01 23 45 67 / 0A 00 00 01 -> oWrEn at addr 0 data 28'h1234567, then at addr 1 data 28'hA000001; oDone one cycle later.
REQ-034 iWordCount=0 -> oDone pulse one cycle after iStart, no oWrEn (checksum disabled).
REQ-035 byte0=8'h1F -> oError=1, no oWrEn, oBusy=0; subsequent valid iStart clears oError and loads normally.
REQ-036 iByteValid toggling every other cycle with iStart pulsed mid-session -> words identical to REQ-033, iStart ignored, no writes while oByteReady=0.
REQ-037 Reset low after 2 bytes of word 1 -> all outputs 0 next cycle, no write; new session writes from addr 0.
REQ-038 LOADER_CHECKSUM_EN, one word 01 02 03 04, checksum 8'h04 -> oDone; checksum 8'h05 -> oError=1, no oDone.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared definitions for the program loader: instruction field
//               widths, bytes per word, opcode set and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;
    localparam int OPCODE_W       = 4;
    localparam int OPERAND_W      = 24;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_JZ    = 4'h9,
        OP_CALL  = 4'hA,
        OP_RET   = 4'hB,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 3'd3
`endif
    } loader_state_e;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : prog_word_packer
// Description : Assembles big-endian serial bytes into one instruction word and
//               flags a first byte whose upper nibble is not zero.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_word_packer
    import prog_loader_pkg::*;
#(
    parameter int INSTR_W = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic [7:0]         i_byte,
    input  logic               i_fire,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_last,
    output logic               o_nibble_err
);

    localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [INSTR_W-1:0]    r_word;
    logic                  w_first;

    assign w_first      = (r_idx == '0);
    assign o_last       = (r_idx == c_LAST_IDX);
    assign o_nibble_err = w_first && (i_byte[7:OPCODE_W] != '0);
    assign o_word       = r_word;

    // The first byte carries only the opcode nibble; later bytes shift in below it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
        end else if (i_fire && !o_nibble_err) begin
            r_idx  <= o_last ? '0 : r_idx + 1'b1;
            r_word <= w_first ? INSTR_W'(i_byte[OPCODE_W-1:0])
                              : {r_word[INSTR_W-9:0], i_byte};
        end
    end

endmodule : prog_word_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial-byte program loader writing instruction memory while the
//               CPU is held. Optional macro LOADER_CHECKSUM_EN adds XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iStart,
    input  logic [ADDR_W-1:0]  iWordCount,
    input  logic [7:0]         iByte,
    input  logic               iByteValid,
    output logic               oByteReady,
    output logic               oWrEn,
    output logic [ADDR_W-1:0]  oWrAddress,
    output logic [INSTR_W-1:0] oWrData,
    output logic               oBusy,
    output logic               oCpuHold,
    output logic               oDone,
    output logic               oError
);

    loader_state_e     r_state;
    loader_state_e     w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              r_err;
    logic              w_start_ok;
    logic              w_pack_fire;
    logic              w_last;
    logic              w_nibble_err;

    assign w_start_ok  = iStart && ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_pack_fire = iByteValid && (r_state == ST_RECV);
    assign w_addr_inc  = r_addr + ADDR_W'(1);

    prog_word_packer #(
        .INSTR_W      (INSTR_W)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start_ok),
        .i_byte       (iByte),
        .i_fire       (w_pack_fire),
        .o_word       (oWrData),
        .o_last       (w_last),
        .o_nibble_err (w_nibble_err)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_pack_fire && !w_nibble_err) begin
            r_csum <= r_csum ^ iByte;
        end
    end

    localparam loader_state_e c_FINAL_ST = ST_CHECK;
`else
    localparam loader_state_e c_FINAL_ST = ST_DONE;
`endif

    always_comb begin
        w_next     = r_state;
        oByteReady = 1'b0;
        oWrEn      = 1'b0;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (iStart) begin
                    w_next = (iWordCount == '0) ? c_FINAL_ST : ST_RECV;
                end
            end
            ST_RECV: begin
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (iByteValid) begin
                    if (w_nibble_err) begin
                        w_next = ST_ERR;
                    end else if (w_last) begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                oWrEn  = 1'b1;
                oBusy  = 1'b1;
                w_next = (w_addr_inc == r_count) ? c_FINAL_ST : ST_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                oByteReady = 1'b1;
                oBusy      = 1'b1;
                if (iByteValid) begin
                    w_next = (iByte == r_csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                oDone  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Counter only advances on a write, so it never wraps past the last address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_addr  <= '0;
                r_count <= iWordCount;
            end else if (r_state == ST_WRITE) begin
                r_addr  <= w_addr_inc;
            end
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_next == ST_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign oWrAddress = r_addr;
    assign oCpuHold   = oBusy;
    assign oError     = r_err;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomized self-checking bench for prog_loader with a word-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 28;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               iStart     = 1'b0;
    logic [ADDR_W-1:0]  iWordCount = '0;
    logic [7:0]         iByte      = '0;
    logic               iByteValid = 1'b0;
    logic               oByteReady;
    logic               oWrEn;
    logic [ADDR_W-1:0]  oWrAddress;
    logic [INSTR_W-1:0] oWrData;
    logic               oBusy;
    logic               oCpuHold;
    logic               oDone;
    logic               oError;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iStart     (iStart),
        .iWordCount (iWordCount),
        .iByte      (iByte),
        .iByteValid (iByteValid),
        .oByteReady (oByteReady),
        .oWrEn      (oWrEn),
        .oWrAddress (oWrAddress),
        .oWrData    (oWrData),
        .oBusy      (oBusy),
        .oCpuHold   (oCpuHold),
        .oDone      (oDone),
        .oError     (oError)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed bus activity
    int                 wr_addr_q[$];
    logic [INSTR_W-1:0] wr_data_q[$];
    int                 wr_cyc_q[$];
    int                 done_cyc_q[$];
    int                 overlap_cnt = 0;
    int                 hold_bad    = 0;

    always @(negedge clk) begin
        if (oWrEn === 1'b1) begin
            wr_addr_q.push_back(int'(oWrAddress));
            wr_data_q.push_back(oWrData);
            wr_cyc_q.push_back(cyc);
        end
        if (oDone === 1'b1) done_cyc_q.push_back(cyc);
        if (oWrEn === 1'b1 && oByteReady === 1'b1) overlap_cnt++;
        if (oCpuHold !== oBusy) hold_bad++;
    end

    // Stimulus and reference model state
    logic [7:0]         tx_data[$];
    logic [7:0]         tx[$];
    int                 exp_addr[$];
    logic [INSTR_W-1:0] exp_data[$];
    bit                 exp_err;
    bit                 exp_done;

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        overlap_cnt = 0;
        hold_bad    = 0;
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        tx_data.push_back(b0);
        tx_data.push_back(b1);
        tx_data.push_back(b2);
        tx_data.push_back(b3);
    endtask

    task automatic build_tx();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        tx.delete();
        foreach (tx_data[i]) begin
            tx.push_back(tx_data[i]);
`ifdef LOADER_CHECKSUM_EN
            x = x ^ tx_data[i];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(x);
`endif
    endtask

    // Words are written in order until the first one with a bad opcode byte.
    task automatic model(input int wc);
        bit stop;
        logic [7:0] b0;
        stop = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        for (int w = 0; w < wc && !stop; w++) begin
            b0 = tx_data[4*w];
            if (b0[7:4] != 4'h0) begin
                exp_err = 1'b1;
                stop    = 1'b1;
            end else begin
                exp_addr.push_back(w);
                exp_data.push_back(INSTR_W'(b0[3:0]) * 28'h1000000 + INSTR_W'(tx_data[4*w+1]) * 28'h10000
                                   + INSTR_W'(tx_data[4*w+2]) * 28'h100 + INSTR_W'(tx_data[4*w+3]));
            end
        end
        exp_done = !exp_err;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] wc);
        iStart     = 1'b1;
        iWordCount = wc;
        @(posedge clk);
        #1;
        iStart     = 1'b0;
        iWordCount = ADDR_W'($urandom);
        @(negedge clk);
    endtask

    task automatic drive_bytes(input bit gaps, input bit noise);
        int idx   = 0;
        int guard = 0;
        bit phase = 1'b0;
        bit xfer;
        while (idx < tx.size()) begin
            if (oBusy !== 1'b1) break;
            if (gaps && phase) begin
                iByteValid = 1'b0;
                iByte      = 8'($urandom);
            end else begin
                iByteValid = 1'b1;
                iByte      = tx[idx];
            end
            iStart     = noise && ($urandom_range(0, 2) == 0);
            iWordCount = ADDR_W'($urandom);
            #1;
            xfer = iByteValid && (oByteReady === 1'b1);
            @(posedge clk);
            if (xfer) idx++;
            phase = ~phase;
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                checks++; fails++;
                $display("FAIL drive_timeout: sent %0d of %0d bytes", idx, tx.size());
                break;
            end
        end
        iByteValid = 1'b0;
        iStart     = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (oBusy === 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            checks++; fails++;
            $display("FAIL idle_timeout: oBusy still %b after %0d cycles", oBusy, g);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({oWrEn, oByteReady, oBusy, oCpuHold, oDone, oError} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000", {oWrEn, oByteReady, oBusy, oCpuHold, oDone, oError});
        end
        checks++;
        if (oWrAddress !== '0 || oWrData !== '0) begin
            fails++;
            $display("FAIL reset_bus: got addr %h data %h expected 0", oWrAddress, oWrData);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy %b done %b expected 0 0", oBusy, oDone);
        end
    endtask

    task automatic test_basic(input bit gaps);
        tx_data.delete();
        push_word(8'h01, 8'h23, 8'h45, 8'h67);
        push_word(8'h0A, 8'h00, 8'h00, 8'h01);
        build_tx();
        model(2);
        clear_mon();
        start_session(ADDR_W'(2));
        drive_bytes(gaps, gaps);
        wait_idle();
        checks++;
        if (wr_data_q.size() != exp_data.size()) begin
            fails++;
            $display("FAIL basic_wr_count(gaps=%0d): got %0d expected %0d", gaps, wr_data_q.size(), exp_data.size());
        end
        for (int i = 0; i < wr_data_q.size() && i < exp_data.size(); i++) begin
            checks++;
            if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                fails++;
                $display("FAIL basic_write%0d: got %0d/%h expected %0d/%h", i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (done_cyc_q.size() != 1) begin
            fails++;
            $display("FAIL basic_done_count: got %0d expected 1", done_cyc_q.size());
        end
`ifndef LOADER_CHECKSUM_EN
        if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
            checks++;
            if (done_cyc_q[0] != wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
                fails++;
                $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
            end
        end
`endif
        checks++;
        if (oError !== 1'b0 || overlap_cnt != 0 || hold_bad != 0) begin
            fails++;
            $display("FAIL basic_side: got err %b overlap %0d hold_bad %0d expected 0 0 0", oError, overlap_cnt, hold_bad);
        end
    endtask

    task automatic test_zero_count();
        clear_mon();
        start_session(ADDR_W'(0));
`ifdef LOADER_CHECKSUM_EN
        tx_data.delete();
        build_tx();
        drive_bytes(1'b0, 1'b0);
        wait_idle();
`else
        checks++;
        if (oDone !== 1'b1) begin
            fails++;
            $display("FAIL zero_done_pulse: got %b expected 1", oDone);
        end
        @(negedge clk);
        checks++;
        if (oDone !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_width: got %b expected 0", oDone);
        end
        repeat (2) @(negedge clk);
`endif
        checks++;
        if (wr_data_q.size() != 0 || done_cyc_q.size() != 1 || oError !== 1'b0) begin
            fails++;
            $display("FAIL zero_summary: got writes %0d dones %0d err %b expected 0 1 0", wr_data_q.size(), done_cyc_q.size(), oError);
        end
    endtask

    task automatic test_nibble_error();
        tx_data.delete();
        push_word(8'h1F, 8'h00, 8'h00, 8'h00);
        push_word(8'h02, 8'h11, 8'h22, 8'h33);
        build_tx();
        clear_mon();
        start_session(ADDR_W'(2));
        drive_bytes(1'b0, 1'b0);
        wait_idle();
        repeat (4) @(negedge clk);
        checks++;
        if (oError !== 1'b1 || oBusy !== 1'b0 || oCpuHold !== 1'b0) begin
            fails++;
            $display("FAIL nib_state: got err %b busy %b hold %b expected 1 0 0", oError, oBusy, oCpuHold);
        end
        checks++;
        if (wr_data_q.size() != 0 || done_cyc_q.size() != 0) begin
            fails++;
            $display("FAIL nib_activity: got writes %0d dones %0d expected 0 0", wr_data_q.size(), done_cyc_q.size());
        end
        tx_data.delete();
        push_word({4'h0, 4'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
        model(1);
        build_tx();
        clear_mon();
        start_session(ADDR_W'(1));
        checks++;
        if (oError !== 1'b0 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL nib_restart: got err %b busy %b expected 0 1", oError, oBusy);
        end
        drive_bytes(1'b0, 1'b0);
        wait_idle();
        checks++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== exp_data[0] || done_cyc_q.size() != 1) begin
            fails++;
            $display("FAIL nib_reload: got writes %0d dones %0d expected 1 write of %h and 1 done", wr_data_q.size(), done_cyc_q.size(), exp_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        tx_data.delete();
        push_word({4'h0, 4'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
        tx_data.push_back({4'h0, 4'($urandom)});
        tx_data.push_back(8'($urandom));
        model(1);
        tx.delete();
        foreach (tx_data[i]) tx.push_back(tx_data[i]);
        clear_mon();
        start_session(ADDR_W'(2));
        drive_bytes(1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({oWrEn, oByteReady, oBusy, oCpuHold, oDone, oError} !== 6'b0 || oWrAddress !== '0 || oWrData !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got flags %b addr %h data %h expected all 0",
                     {oWrEn, oByteReady, oBusy, oCpuHold, oDone, oError}, oWrAddress, oWrData);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== exp_data[0]) begin
            fails++;
            $display("FAIL midreset_writes: got %0d writes expected only word %h", wr_data_q.size(), exp_data[0]);
        end
        tx_data.delete();
        push_word({4'h0, 4'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
        model(1);
        build_tx();
        clear_mon();
        start_session(ADDR_W'(1));
        drive_bytes(1'b0, 1'b0);
        wait_idle();
        checks++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] !== exp_data[0]) begin
            fails++;
            $display("FAIL midreset_reload: got %0d writes expected addr 0 data %h", wr_data_q.size(), exp_data[0]);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 10; s++) begin
            int wc;
            int bad;
            logic [7:0] b0;
            wc  = $urandom_range(1, 6);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wc - 1) : -1;
            tx_data.delete();
            for (int w = 0; w < wc; w++) begin
                b0 = (w == bad) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)};
                push_word(b0, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            model(wc);
            build_tx();
            clear_mon();
            start_session(ADDR_W'(wc));
            drive_bytes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle();
            checks++;
            if (wr_data_q.size() != exp_data.size()) begin
                fails++;
                $display("FAIL rand%0d_wr_count: got %0d expected %0d", s, wr_data_q.size(), exp_data.size());
            end
            for (int i = 0; i < wr_data_q.size() && i < exp_data.size(); i++) begin
                checks++;
                if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    fails++;
                    $display("FAIL rand%0d_write%0d: got %0d/%h expected %0d/%h", s, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
            end
            checks++;
            if (done_cyc_q.size() != int'(exp_done) || oError !== exp_err || overlap_cnt != 0 || hold_bad != 0) begin
                fails++;
                $display("FAIL rand%0d_status: got dones %0d err %b overlap %0d hold_bad %0d expected %0d %b 0 0",
                         s, done_cyc_q.size(), oError, overlap_cnt, hold_bad, exp_done, exp_err);
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            tx_data.delete();
            push_word(8'h01, 8'h02, 8'h03, 8'h04);
            tx.delete();
            foreach (tx_data[i]) tx.push_back(tx_data[i]);
            tx.push_back((k == 0) ? 8'h04 : 8'h05);
            clear_mon();
            start_session(ADDR_W'(1));
            drive_bytes(1'b0, 1'b0);
            wait_idle();
            checks++;
            if (wr_data_q.size() != 1 || done_cyc_q.size() != ((k == 0) ? 1 : 0) || oError !== ((k == 0) ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL csum%0d: got writes %0d dones %0d err %b", k, wr_data_q.size(), done_cyc_q.size(), oError);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_zero_count();
        test_nibble_error();
        test_basic(1'b1);
        test_reset_mid();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prog_loader
`default_nettype wire
